// File: rtl/seq_det_pkg.sv
// Shared constants, mode type and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  localparam int unsigned LEN_MAX   = 32;
  localparam int unsigned DEF_LEN   = 6;
  localparam int unsigned CNT_W_MAX = 32;
  localparam int unsigned CW1       = CNT_W_MAX + 1;

  localparam logic [DEF_LEN-1:0] DEF_PATTERN = 6'b101111;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } ovl_mode_e;

  // Increment v, saturating at the all-ones value of a w-bit counter (w <= CNT_W_MAX).
  function automatic logic [CNT_W_MAX-1:0] sat_inc(input logic [CNT_W_MAX-1:0] v,
                                                   input int unsigned          w);
    logic [CW1-1:0] lim;
    lim = (CW1'(1) << w) - CW1'(1);
    if ({1'b0, v} >= lim) begin
      return CNT_W_MAX'(lim);
    end
    return v + CNT_W_MAX'(1);
  endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating detection counter with synchronous clear and a sticky saturation flag.
module seq_det_match_cnt
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_ONES = '1;

  logic [CNT_W-1:0] cnt_d;
  logic             sat_d;

  // Clear takes effect first; a coincident increment then lands on zero.
  always_comb begin
    cnt_d = clr ? '0 : cnt;
    if (inc) begin
      cnt_d = CNT_W'(sat_inc(CNT_W_MAX'(cnt_d), CNT_W));
    end
    sat_d = (clr ? 1'b0 : sat) | (cnt_d == CNT_ONES);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_d;
      sat <= sat_d;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial Mealy sequence detector with run-time overlap mode and match counter.
// Optional run-time loadable pattern when SEQDET_PROG_EN is defined.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned    LEN     = DEF_LEN,
  parameter logic [LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             clr,
`ifdef SEQDET_PROG_EN
  input  logic             pat_load,
  input  logic [LEN-1:0]   pat_in,
`endif
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned   HW        = LEN - 1;
  localparam int unsigned   FW        = $clog2(LEN);
  localparam logic [FW-1:0] FILL_FULL = FW'(LEN - 1);

  logic [HW-1:0]  hist_q, hist_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic [LEN-1:0] pat_c;
  logic           load_c;
  logic           full_c;
  logic           hit_c;
  ovl_mode_e      mode_c;

`ifdef SEQDET_PROG_EN
  logic [LEN-1:0] pat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= PATTERN;
    end else if (pat_load) begin
      pat_q <= pat_in;
    end
  end

  assign pat_c  = pat_q;
  assign load_c = pat_load;
`else
  assign pat_c  = PATTERN;
  assign load_c = 1'b0;
`endif

  // Match needs a full history window; a pattern load suppresses the strobe.
  assign full_c = (fill_q == FILL_FULL);
  assign hit_c  = en & full_c & ({hist_q, x} == pat_c) & ~load_c;
  assign z      = hit_c;
  assign mode_c = ovl_mode_e'(overlap);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (load_c) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      if (hit_c && (mode_c == MODE_NONOVL)) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = HW'({hist_q, x});
        fill_d = full_c ? fill_q : fill_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  seq_det_match_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (hit_c),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: default instance plus a CNT_W=2 instance.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst, en, x, overlap, clr;
  logic       z_a, sat_a;
  logic [7:0] cnt_a;
  logic       z_b, sat_b;
  logic [1:0] cnt_b;
`ifdef SEQDET_PROG_EN
  logic       pat_load;
  logic [5:0] pat_in;
`endif

  always #5 clk = ~clk;

  seq_detector_param #(.LEN(6), .PATTERN(6'b101111), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .clr(clr),
`ifdef SEQDET_PROG_EN
    .pat_load(pat_load), .pat_in(pat_in),
`endif
    .z(z_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  seq_detector_param #(.LEN(6), .PATTERN(6'b101111), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .clr(clr),
`ifdef SEQDET_PROG_EN
    .pat_load(pat_load), .pat_in(pat_in),
`endif
    .z(z_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  localparam int K_Z   = 0;
  localparam int K_CNT = 1;
  localparam int K_SAT = 2;

  typedef struct {
    int    kind;
    int    sel;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  bit seq     [20] = '{1,1,0,1,1,1,1,0,0,1,0,1,1,1,1,0,1,1,1,1};
  bit z_ovl   [20] = '{0,0,0,0,0,0,1,0,0,0,0,0,0,0,1,0,0,0,0,1};
  bit z_nonovl[20] = '{0,0,0,0,0,0,1,0,0,0,0,0,0,0,1,0,0,0,0,0};

  task automatic push(input int kind, input int sel, input int exp, input string name);
    exp_t e;
    e.kind = kind;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.kind)
        K_Z:     act = (e.sel == 0) ? {31'b0, z_a}   : {31'b0, z_b};
        K_CNT:   act = (e.sel == 0) ? {24'b0, cnt_a} : {30'b0, cnt_b};
        default: act = (e.sel == 0) ? {31'b0, sat_a} : {31'b0, sat_b};
      endcase
      n_chk++;
      if (act !== 32'(e.exp)) begin
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d", e.name, act, e.exp);
      end
    end
  end

  task automatic cyc(input bit xv, input bit ev, input bit cv, input bit ez, input string nm);
    @(posedge clk); #1;
    x = xv; en = ev; clr = cv;
`ifdef SEQDET_PROG_EN
    pat_load = 1'b0;
`endif
    push(K_Z, 0, int'(ez), {nm, "/a"});
    push(K_Z, 1, int'(ez), {nm, "/b"});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    x = 1'b0; en = 1'b0; clr = 1'b0;
`ifdef SEQDET_PROG_EN
    pat_load = 1'b0;
`endif
  endtask

  task automatic reset_pulse(input string nm);
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1; x = 1'b1; clr = 1'b0;
    push(K_Z,   0, 0, {nm, "_z"});
    push(K_CNT, 0, 0, {nm, "_cnt_a"});
    push(K_CNT, 1, 0, {nm, "_cnt_b"});
    push(K_SAT, 1, 0, {nm, "_sat_b"});
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0;
  endtask

  task automatic feed(input bit bits[$], input int hit_last, input string nm);
    foreach (bits[i]) cyc(bits[i], 1'b1, 1'b0, (hit_last != 0) && (i == bits.size() - 1), nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b1; x = 1'b1; overlap = 1'b1; clr = 1'b0;
`ifdef SEQDET_PROG_EN
    pat_load = 1'b0; pat_in = '0;
`endif
    #1;
    push(K_Z,   0, 0, "rst_z_a");
    push(K_Z,   1, 0, "rst_z_b");
    push(K_CNT, 0, 0, "rst_cnt_a");
    push(K_SAT, 0, 0, "rst_sat_a");
    push(K_CNT, 1, 0, "rst_cnt_b");
    push(K_SAT, 1, 0, "rst_sat_b");
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0;

    // Overlapping detection
    overlap = 1'b1;
    for (int i = 0; i < 20; i++) cyc(seq[i], 1'b1, 1'b0, z_ovl[i], $sformatf("ovl_z[%0d]", i));
    idle();
    push(K_CNT, 0, 3, "ovl_cnt_a");
    push(K_SAT, 0, 0, "ovl_sat_a");
    push(K_CNT, 1, 3, "ovl_cnt_b");
    push(K_SAT, 1, 1, "ovl_sat_b");

    // Non-overlapping detection
    reset_pulse("rst2");
    overlap = 1'b0;
    for (int i = 0; i < 20; i++) cyc(seq[i], 1'b1, 1'b0, z_nonovl[i], $sformatf("novl_z[%0d]", i));
    idle();
    push(K_CNT, 0, 2, "novl_cnt_a");

    // Enable gaps with x toggling
    reset_pulse("rst3");
    overlap = 1'b1;
    feed('{1,0,1,1}, 0, "gap_pre");
    for (int i = 0; i < 3; i++) cyc(bit'(i % 2 == 0), 1'b0, 1'b0, 1'b0, $sformatf("gap1_z[%0d]", i));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, "gap_b4");
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, $sformatf("gap2_z[%0d]", i));
    cyc(1'b1, 1'b1, 1'b0, 1'b1, "gap_last");
    idle();
    push(K_CNT, 0, 1, "gap_cnt_a");

    // Reset mid-pattern discards history
    reset_pulse("rst4");
    feed('{1,0,1,1}, 0, "mid_pre");
    reset_pulse("rst_mid");
    feed('{1,1}, 0, "mid_post");
    feed('{1,0,1,1,1,1}, 1, "mid_full");
    idle();
    push(K_CNT, 0, 1, "mid_cnt_a");

    // Saturation of the 2-bit counter, then clear coincident with a match
    reset_pulse("rst5");
    overlap = 1'b1;
    feed('{1,0,1,1,1,1}, 1, "sat_m1");
    for (int m = 2; m <= 5; m++) begin
      feed('{0,1,1,1,1}, 1, $sformatf("sat_m%0d", m));
      if (m == 2) begin
        idle();
        push(K_CNT, 1, 2, "sat_cnt_b_m2");
        push(K_SAT, 1, 0, "sat_flag_b_m2");
      end
      if (m == 3) begin
        idle();
        push(K_CNT, 1, 3, "sat_cnt_b_m3");
        push(K_SAT, 1, 1, "sat_flag_b_m3");
      end
    end
    idle();
    push(K_CNT, 1, 3, "sat_cnt_b_m5");
    push(K_SAT, 1, 1, "sat_flag_b_m5");
    push(K_CNT, 0, 5, "sat_cnt_a_m5");
    feed('{0,1,1,1}, 0, "clr_pre");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, "clr_hit");
    idle();
    push(K_CNT, 1, 1, "clr_cnt_b");
    push(K_SAT, 1, 0, "clr_sat_b");
    push(K_CNT, 0, 1, "clr_cnt_a");
    push(K_SAT, 0, 0, "clr_sat_a");

`ifdef SEQDET_PROG_EN
    // Pattern load: strobe suppressed on the load cycle, new pattern then in force
    reset_pulse("rst6");
    overlap = 1'b1;
    feed('{1,0,1,1,1}, 0, "prog_pre");
    @(posedge clk); #1;
    x = 1'b1; en = 1'b1; clr = 1'b0; pat_load = 1'b1; pat_in = 6'b110011;
    push(K_Z, 0, 0, "prog_load_z");
    feed('{1,1,0,0,1,1}, 1, "prog_new");
    feed('{0,1,1,1,1}, 0, "prog_old");
    idle();
    push(K_CNT, 0, 1, "prog_cnt_a");
`endif

    idle();
    repeat (3) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
